// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings, segment codes
// and digit-slot indices used by the counters and the display scanner.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_SEC  = 2'b11
    } mode_e;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [2:0] DIG_SEC_U  = 3'd0;
    localparam logic [2:0] DIG_SEC_T  = 3'd1;
    localparam logic [2:0] DIG_MIN_U  = 3'd2;
    localparam logic [2:0] DIG_MIN_T  = 3'd3;
    localparam logic [2:0] DIG_HOUR_U = 3'd4;
    localparam logic [2:0] DIG_HOUR_T = 3'd5;

    localparam logic [5:0] AN_OFF      = 6'b111111;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal
// codes render as a dash so invalid fields are visibly flagged.
module bcd_to_seg
    import clock_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_c_o = 7'b1000000;
            4'd1:    seg_c_o = 7'b1111001;
            4'd2:    seg_c_o = 7'b0100100;
            4'd3:    seg_c_o = 7'b0110000;
            4'd4:    seg_c_o = 7'b0011001;
            4'd5:    seg_c_o = 7'b0010010;
            4'd6:    seg_c_o = 7'b0000010;
            4'd7:    seg_c_o = 7'b1111000;
            4'd8:    seg_c_o = 7'b0000000;
            4'd9:    seg_c_o = 7'b0010000;
            default: seg_c_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed hh.mm.ss display driver with per-frame snapshot
// of the time counters and blinking of the field being set.
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [1:0] select_mode,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         dig_q, dig_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [1:0]         mode_raw_q;
    mode_e              mode_snap_q;
    logic [4:0]         hour_q;
    logic [5:0]         min_q;
    logic [5:0]         sec_q;
    logic [5:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               scan_wrap, frame_wrap, mode_chg, blink_tc;
    logic               field_sel, slot_blank;
    logic               hour_ok, min_ok, sec_ok;
    bcd2_t              hour_bcd, min_bcd, sec_bcd;
    logic [3:0]         digit;
    logic [6:0]         digit_seg;

    // Constant-compare split into tens/units; inputs never exceed 63.
    function automatic bcd2_t to_bcd(input logic [5:0] v);
        if      (v >= 6'd60) return {4'd6, 4'(v - 6'd60)};
        else if (v >= 6'd50) return {4'd5, 4'(v - 6'd50)};
        else if (v >= 6'd40) return {4'd4, 4'(v - 6'd40)};
        else if (v >= 6'd30) return {4'd3, 4'(v - 6'd30)};
        else if (v >= 6'd20) return {4'd2, 4'(v - 6'd20)};
        else if (v >= 6'd10) return {4'd1, 4'(v - 6'd10)};
        else                 return {4'd0, 4'(v)};
    endfunction

    always_comb begin
        scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        frame_wrap  = scan_wrap && (dig_q == DIG_HOUR_T);
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        dig_d       = dig_q;
        if (scan_wrap) begin
            dig_d = (dig_q == DIG_HOUR_T) ? DIG_SEC_U : dig_q + 3'd1;
        end

        // A mode edit restarts the blink so the new field shows up at once.
        mode_chg    = (select_mode != mode_raw_q);
        blink_tc    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = (mode_chg || blink_tc) ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
        if (mode_chg) begin
            blink_on_d = 1'b1;
        end else if (blink_tc) begin
            blink_on_d = ~blink_on_q;
        end
    end

    always_comb begin
        hour_bcd = to_bcd({1'b0, hour_q});
        min_bcd  = to_bcd(min_q);
        sec_bcd  = to_bcd(sec_q);
        hour_ok  = (hour_q <= 5'd23);
        min_ok   = (min_q <= 6'd59);
        sec_ok   = (sec_q <= 6'd59);

        digit = BCD_INVALID;
        case (dig_q)
            DIG_SEC_U:  digit = sec_ok  ? sec_bcd.units  : BCD_INVALID;
            DIG_SEC_T:  digit = sec_ok  ? sec_bcd.tens   : BCD_INVALID;
            DIG_MIN_U:  digit = min_ok  ? min_bcd.units  : BCD_INVALID;
            DIG_MIN_T:  digit = min_ok  ? min_bcd.tens   : BCD_INVALID;
            DIG_HOUR_U: digit = hour_ok ? hour_bcd.units : BCD_INVALID;
            DIG_HOUR_T: digit = hour_ok ? hour_bcd.tens  : BCD_INVALID;
            default:    digit = BCD_INVALID;
        endcase

        field_sel = 1'b0;
        case (mode_snap_q)
            MODE_SET_HOUR: field_sel = (dig_q == DIG_HOUR_U) || (dig_q == DIG_HOUR_T);
            MODE_SET_MIN:  field_sel = (dig_q == DIG_MIN_U)  || (dig_q == DIG_MIN_T);
            MODE_SET_SEC:  field_sel = (dig_q == DIG_SEC_U)  || (dig_q == DIG_SEC_T);
            default:       field_sel = 1'b0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i   (digit),
        .seg_c_o (digit_seg)
    );

    // First cycle of every slot is a dead band so the previous digit cannot ghost.
    always_comb begin
        slot_blank = (scan_cnt_q == '0) || (field_sel && !blink_on_q);
        an_d       = AN_OFF;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b1;
        if (!slot_blank) begin
            an_d  = ~(6'b000001 << dig_q);
            seg_d = digit_seg;
            dp_d  = !((dig_q == DIG_MIN_U) || (dig_q == DIG_HOUR_U));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            dig_q       <= DIG_SEC_U;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            mode_raw_q  <= MODE_RUN;
            mode_snap_q <= MODE_RUN;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            mode_raw_q  <= select_mode;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            if (frame_wrap) begin
                hour_q      <= hour;
                min_q       <= min;
                sec_q       <= sec;
                mode_snap_q <= mode_e'(select_mode);
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLINK_DIV=32.
module tb_clock_display_scan;

    typedef struct packed {
        logic       care;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] select_mode;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int onehot_viol = 0;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .select_mode (select_mode),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always @(negedge clk) begin
        if ($countones(~an) > 1) onehot_viol++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected outputs for the slot whose state count is c; digs packs
    // hour-tens..sec-units as nibbles, F meaning a dashed digit.
    function automatic exp_t exp_out(input int c, input logic [1:0] m, input bit bon,
                                     input logic [23:0] digs);
        exp_t e;
        int   s;
        int   d;
        logic sel;
        s = c % 4;
        d = (c / 4) % 6;
        e.care = 1'b1;
        e.an   = 6'b111111;
        e.seg  = 7'b1111111;
        e.dp   = 1'b1;
        if (s == 0) return e;
        case (m)
            2'b01:   sel = (d >= 4);
            2'b10:   sel = (d == 2) || (d == 3);
            2'b11:   sel = (d <= 1);
            default: sel = 1'b0;
        endcase
        if (sel && !bon) begin
            e.care = 1'b0;
            return e;
        end
        e.an[d] = 1'b0;
        e.seg   = seg_of(digs[d*4 +: 4]);
        e.dp    = !((d == 2) || (d == 4));
        return e;
    endfunction

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1; hour = 5'd12; min = 6'd34; sec = 6'd56; select_mode = 2'b00;
        tick; tick;
        n_total++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1)
            $display("FAIL reset_state an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
        else n_pass++;
        rst = 1'b0; cyc = 0;
        tick;
        n_total++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1)
            $display("FAIL first_guard an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
        else n_pass++;
        tick;
        n_total++;
        if (an !== 6'b111110 || seg !== 7'b1000000 || dp !== 1'b1)
            $display("FAIL first_digit an=%b seg=%b dp=%b want 111110 1000000 1", an, seg, dp);
        else n_pass++;
    endtask

    task automatic test_run;
        exp_t e;
        for (int k = 3; k <= 72; k++) begin
            tick;
            e = exp_out(cyc - 1, 2'b00, 1'b1, ((cyc - 1) < 24) ? 24'h000000 : 24'h123456);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL run c=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         cyc - 1, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot;
        exp_t e;
        int   fr;
        while ((cyc - 1) % 24 != 9) tick;
        fr  = (cyc - 1) / 24;
        min = 6'd35;
        for (int i = 0; i < 26; i++) begin
            tick;
            e = exp_out(cyc - 1, 2'b00, 1'b1, ((cyc - 1) / 24 == fr) ? 24'h123456 : 24'h123556);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL snapshot c=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         cyc - 1, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
        end
    endtask

    task automatic test_blink;
        exp_t e;
        while ((cyc - 1) % 24 != 22) tick;
        min = 6'd7; select_mode = 2'b10;
        tick;
        e = exp_out(cyc - 1, 2'b00, 1'b1, 24'h123556);
        n_total++;
        if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
            $display("FAIL blink_wrap c=%0d an=%b want %b seg=%b want %b", cyc - 1, an, e.an, seg, e.seg);
        else n_pass++;
        for (int j = 1; j <= 106; j++) begin
            tick;
            e = exp_out(cyc - 1, 2'b10, (((j - 1) / 32) % 2) == 0, 24'h120756);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL blink j=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         j, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
        end
    endtask

    task automatic test_mode_switch;
        exp_t e;
        bit   bon;
        select_mode = 2'b11;
        for (int t = 1; t <= 60; t++) begin
            tick;
            bon = (t == 1) ? 1'b0 : ((((t - 2) / 32) % 2) == 0);
            e = exp_out(cyc - 1, (t <= 14) ? 2'b10 : 2'b11, bon, 24'h120756);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL mode_switch t=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         t, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
        end
    endtask

    task automatic test_range;
        exp_t e;
        hour = 5'd23; min = 6'd59; sec = 6'd59; select_mode = 2'b00;
        tick; tick;
        for (int i = 0; i < 48; i++) begin
            tick;
            e = exp_out(cyc - 1, 2'b00, 1'b1, (i < 24) ? 24'h235959 : 24'hFFFF56);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL range i=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         i, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
            if (i == 22) begin
                hour = 5'd25; min = 6'd60; sec = 6'd56;
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   fr;
        bit   bon;
        for (int i = 0; i < 10; i++) tick;
        select_mode = 2'b11; rst = 1'b1;
        tick;
        n_total++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1)
            $display("FAIL reset_mid an=%b seg=%b dp=%b want 111111 1111111 1", an, seg, dp);
        else n_pass++;
        rst = 1'b0; cyc = 0;
        for (int k = 1; k <= 72; k++) begin
            tick;
            fr  = (cyc - 1) / 24;
            bon = (cyc < 2) ? 1'b1 : ((((cyc - 2) / 32) % 2) == 0);
            e = exp_out(cyc - 1, (fr == 0) ? 2'b00 : 2'b11, bon, (fr == 0) ? 24'h000000 : 24'hFFFF56);
            n_total++;
            if (an !== e.an || dp !== e.dp || (e.care && seg !== e.seg))
                $display("FAIL after_reset k=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         k, an, e.an, seg, e.seg, dp, e.dp);
            else n_pass++;
        end
    endtask

    task automatic test_onehot;
        n_total++;
        if (onehot_viol !== 0)
            $display("FAIL onehot_an violations=%0d want 0", onehot_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_run;
        test_snapshot;
        test_blink;
        test_mode_switch;
        test_range;
        test_reset_mid;
        test_onehot;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
